// File: rtl/single_port_ram_ctrl.sv
// Request sequencer for a single-port RAM on a shared tri-state data bus.
// Optional power-up clear of the whole array is enabled with `define RAM_CTRL_INIT_EN.
module single_port_ram_ctrl #(
  parameter int ADDRWIDTH = 4,
  parameter int DATAWIDTH = 8,
  parameter int SIZE      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDRWIDTH-1:0] req_addr,
  input  logic [DATAWIDTH-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATAWIDTH-1:0] rsp_rdata,
  output logic                 init_done,
  output logic                 ram_cs,
  output logic                 ram_we,
  output logic                 ram_oe,
  output logic [ADDRWIDTH-1:0] ram_addr,
  inout  wire  [DATAWIDTH-1:0] ram_data
);

  if (SIZE > (1 << ADDRWIDTH)) begin : g_size_chk
    $error("SIZE exceeds the address space");
  end

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ISS,
    RD_DRV,
    RESP
`ifdef RAM_CTRL_INIT_EN
    , INIT
`endif
  } state_t;

  state_t                 state, state_nxt;
  logic [ADDRWIDTH-1:0]   addr_q;
  logic [DATAWIDTH-1:0]   wdata_q;
  logic [DATAWIDTH-1:0]   rdata_q;
  logic                   init_done_q;
  logic                   bus_drive;
  logic [DATAWIDTH-1:0]   bus_out;

`ifdef RAM_CTRL_INIT_EN
  logic [ADDRWIDTH-1:0]   cnt;
  logic                   cnt_last;
  assign cnt_last = (cnt == ADDRWIDTH'(SIZE - 1));
`endif

  // init_done doubles as the gate on req_ready, so everything reads 0 while rst is held
  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef RAM_CTRL_INIT_EN
      state <= INIT;
      cnt   <= '0;
`else
      state <= IDLE;
`endif
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      init_done_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid && req_ready) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == RD_DRV) begin
        rdata_q <= ram_data;
      end
`ifdef RAM_CTRL_INIT_EN
      if (state == INIT) begin
        cnt <= cnt + 1'b1;
        if (cnt_last) begin
          init_done_q <= 1'b1;
        end
      end
`else
      init_done_q <= 1'b1;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_oe    = 1'b0;
    bus_drive = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = init_done_q;
        if (req_valid && init_done_q) begin
          state_nxt = req_we ? WR : RD_ISS;
        end
      end
      WR: begin
        ram_cs    = 1'b1;
        ram_we    = 1'b1;
        bus_drive = 1'b1;
        state_nxt = IDLE;
      end
      RD_ISS: begin
        ram_cs    = 1'b1;
        state_nxt = RD_DRV;
      end
      RD_DRV: begin
        ram_cs    = 1'b1;
        ram_oe    = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
`ifdef RAM_CTRL_INIT_EN
      INIT: begin
        ram_cs    = 1'b1;
        ram_we    = 1'b1;
        bus_drive = 1'b1;
        if (cnt_last) begin
          state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

`ifdef RAM_CTRL_INIT_EN
  assign ram_addr = (state == INIT) ? cnt : addr_q;
  assign bus_out  = (state == INIT) ? '0 : wdata_q;
`else
  assign ram_addr = addr_q;
  assign bus_out  = wdata_q;
`endif

  assign ram_data  = bus_drive ? bus_out : 'z;
  assign rsp_rdata = rdata_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_single_port_ram_ctrl.sv
// Self-checking bench for single_port_ram_ctrl: RAM model on the shared bus,
// transaction-level reference model compared every cycle, directed plus random traffic.
module tb_single_port_ram_ctrl;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int SZ = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic          ram_cs, ram_we, ram_oe;
  logic [AW-1:0] ram_addr;
  wire  [DW-1:0] ram_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  single_port_ram_ctrl #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .SIZE(SZ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
    .ram_addr(ram_addr), .ram_data(ram_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // RAM macro: synchronous write, registered read word driven while oe is high
  logic [DW-1:0] ram_mem [SZ];
  logic [DW-1:0] ram_q;
  always @(posedge clk) begin
    if (ram_cs && ram_we) ram_mem[ram_addr] <= ram_data;
    if (ram_cs && !ram_we) ram_q <= ram_mem[ram_addr];
  end
  assign ram_data = (ram_cs && ram_oe) ? ram_q : 'z;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one transaction tracked by edges elapsed since acceptance
  logic [DW-1:0] gold [SZ];
  bit            armed   = 0;
  bit            m_ok    = 0;
  int            m_phase = 0;
  bit            m_we    = 0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata = '0;
  bit            m_initing = 0;
  int            m_icnt    = 0;

  initial begin
    for (int i = 0; i < SZ; i++) begin
      gold[i]    = '0;
      ram_mem[i] = '0;
    end
  end

  always @(posedge clk) begin
    bit was_ok;
    was_ok = m_ok;
    if (armed && m_initing) gold[m_icnt] = '0;
    if (m_phase == 1 && m_we) gold[m_addr] = m_wdata;
    if (rst) begin
      armed   = 1;
      m_phase = 0;
      m_ok    = 0;
      m_addr  = '0;
      m_wdata = '0;
      m_rdata = '0;
`ifdef RAM_CTRL_INIT_EN
      m_initing = 1;
      m_icnt    = 0;
`endif
    end else if (armed) begin
      if (m_initing) begin
        if (m_icnt == SZ - 1) begin
          m_initing = 0;
          m_ok      = 1;
        end else begin
          m_icnt++;
        end
      end else begin
        m_ok = 1;
      end
      case (m_phase)
        0: if (was_ok && req_valid) begin
          m_phase = 1;
          m_we    = req_we;
          m_addr  = req_addr;
          m_wdata = req_wdata;
        end
        1: m_phase = m_we ? 0 : 2;
        2: begin
          m_phase = 3;
          m_rdata = gold[m_addr];
        end
        default: if (rsp_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      logic e_cs, e_we, e_oe;
      e_cs = (m_phase == 1) || (m_phase == 2) || m_initing;
      e_we = (m_phase == 1 && m_we) || m_initing;
      e_oe = (m_phase == 2) && !m_we;
      check("req_ready", req_ready, (m_phase == 0) && m_ok);
      check("rsp_valid", rsp_valid, m_phase == 3);
      check("rsp_rdata", rsp_rdata, m_rdata);
      check("init_done", init_done, m_ok);
      check("ram_cs", ram_cs, e_cs);
      check("ram_we", ram_we, e_we);
      check("ram_oe", ram_oe, e_oe);
      check("oe_we_excl", ram_oe & ram_we, 0);
      check("ram_addr", ram_addr, m_initing ? AW'(m_icnt) : m_addr);
      if (e_we) check("bus_wdata", ram_data, m_initing ? '0 : m_wdata);
      if (e_oe) check("bus_rdata", ram_data, gold[m_addr]);
    end
  end

  task automatic xact(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input int hold, output logic [DW-1:0] rd, output int lat);
    int n;
    rd = '0;
    lat = 0;
    req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) begin
      check("ready_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (we) return;
    rsp_ready = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    if (!rsp_valid) begin
      check("rsp_timeout", 0, 1);
      return;
    end
    repeat (hold) begin
      @(posedge clk); #1;
    end
    rd = rsp_rdata;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!init_done && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!init_done) check("init_timeout", 0, 1);
  endtask

  initial begin
    logic [DW-1:0] rd;
    int lat, n, prev, acc;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cs", ram_cs, 0);
    check("rst_ready", req_ready, 0);
    rst = 1'b0;

    // bring-up
    wait_init(n);
`ifdef RAM_CTRL_INIT_EN
    check("init_cycles", n, 16);
`else
    check("ready_after_rst", n, 1);
`endif
    check("t1_ready", req_ready, 1);
    check("t1_cs", ram_cs, 0);

    // write then read back
    xact(1, 4'd3, 8'hA5, 0, rd, lat);
    xact(0, 4'd3, 8'h00, 0, rd, lat);
    check("t2_lat", lat, 3);
    check("t2_data", rd, 8'hA5);

    // response held back by the client
    xact(1, 4'd5, 8'h5A, 0, rd, lat);
    xact(0, 4'd5, 8'h00, 4, rd, lat);
    check("t3_data", rd, 8'h5A);

    // back-to-back writes with req_valid held high
    req_valid = 1'b1; req_we = 1'b1; prev = -1;
    for (int i = 0; i < SZ; i++) begin
      req_addr = AW'(i); req_wdata = DW'(i) ^ 8'hFF;
      n = 0;
      while (!req_ready && n < 20) begin
        @(posedge clk); #1; n++;
      end
      @(posedge clk);
      acc = cyc;
      #1;
      if (prev >= 0) check("t4_spacing", acc - prev, 2);
      prev = acc;
    end
    req_valid = 1'b0;
    for (int i = 0; i < SZ; i++) begin
      xact(0, AW'(i), 8'h00, 0, rd, lat);
      check("t4_readback", rd, DW'(i) ^ 8'hFF);
    end

    // reset while the bus is turned around for a read
    req_we = 1'b0; req_addr = 4'd2; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("t5_in_drv", ram_oe, 1);
    pulse_rst();
    check("t5_valid", rsp_valid, 0);
    check("t5_cs", ram_cs | ram_we | ram_oe, 0);
    wait_init(n);

`ifdef RAM_CTRL_INIT_EN
    xact(1, 4'd7, 8'h3C, 0, rd, lat);
    pulse_rst();
    wait_init(n);
    xact(0, 4'd7, 8'h00, 0, rd, lat);
    check("t6_cleared", rd, 8'h00);
`endif

    // randomized traffic with occasional idle-time resets
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      if ($urandom_range(0, 39) == 0) begin
        pulse_rst();
        wait_init(n);
      end
      rsp_ready = 1'($urandom_range(0, 1));
      xact(1'($urandom_range(0, 1)), AW'($urandom_range(0, SZ - 1)), DW'($urandom),
           int'($urandom_range(0, 3)), rd, lat);
      if (lat != 0) check("rnd_lat", lat, 3);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end
endmodule
